// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle shared by the UART TX arbiter. The slave modport is the arbiter;
// the master modport is the surrounding requesters plus the transmitter busy flag.
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ = 4
) ();
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;

    modport master (
        output req, req_data, tx_busy,
        input  grant, ack, err, tx_start, tx_data
    );

    modport slave (
        input  req, req_data, tx_busy,
        output grant, ack, err, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// Optional watchdog on the busy handshake is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter logic [15:0] TIMEOUT_CYC = 16'd60000
) (
    input logic             clk,
    input logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {StIdle, StStart, StWaitBusy, StWaitDone, StAck} state_e;

    state_e          state_q;
    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] winner_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] ack_q;
    logic            tx_start_q;
    logic [7:0]      tx_data_q;

    logic [IdxW-1:0] win_idx;
    logic            win_found;
    logic [IdxW:0]   cand;
    logic [NREQ-1:0] win_onehot;
    logic [7:0]      win_byte;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        err_q;
`endif

    // Search ptr, ptr+1, ... wrapping modulo NREQ; first asserted request wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IdxW + 1)'(i);
            if (cand >= (IdxW + 1)'(NREQ)) begin
                cand = cand - (IdxW + 1)'(NREQ);
            end
            if (!win_found && bus.req[cand[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdxW-1:0];
            end
        end
        win_onehot = {{(NREQ - 1){1'b0}}, 1'b1} << win_idx;
        win_byte   = bus.req_data[{win_idx, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            winner_q   <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        grant_q    <= win_onehot;
                        winner_q   <= win_idx;
                        tx_data_q  <= win_byte;
                        tx_start_q <= 1'b1;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    tx_start_q <= 1'b0;
                    state_q    <= StWaitBusy;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_q      <= '0;
`endif
                end
                StWaitBusy: begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (bus.tx_busy) begin
                        cnt_q   <= '0;
                        state_q <= StWaitDone;
                    end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
                        ack_q   <= grant_q;
                        err_q   <= 1'b1;
                        state_q <= StAck;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`else
                    if (bus.tx_busy) begin
                        state_q <= StWaitDone;
                    end
`endif
                end
                StWaitDone: begin
                    if (!bus.tx_busy) begin
                        ack_q   <= grant_q;
                        state_q <= StAck;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
                        ack_q   <= grant_q;
                        err_q   <= 1'b1;
                        state_q <= StAck;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
`endif
                    end
                end
                StAck: begin
                    ack_q   <= '0;
                    grant_q <= '0;
                    ptr_q   <= (winner_q == IdxW'(NREQ - 1)) ? '0 : winner_q + 1'b1;
                    state_q <= StIdle;
`ifdef UART_ARB_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.ack      = ack_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;

`ifdef UART_ARB_TIMEOUT_EN
    assign bus.err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
    localparam int unsigned NREQ = 4;
    localparam logic [15:0] TCYC = 16'd20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NREQ       (NREQ),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Transmitter model: busy rises the edge after tx_start is seen, for busy_len cycles.
    int   busy_len  = 3;
    int   busy_left = 0;
    logic busy_r    = 1'b0;
    int   stuck     = 0;  // 0 normal, 1 forced low, 2 forced high
    always @(posedge clk) begin
        if (!rst) begin
            busy_r    <= 1'b0;
            busy_left <= 0;
        end else if (bus.tx_start) begin
            busy_r    <= 1'b1;
            busy_left <= busy_len;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_r    <= 1'b0;
            busy_left <= 0;
        end
    end
    assign bus.tx_busy = (stuck == 2) ? 1'b1 : (stuck == 1) ? 1'b0 : busy_r;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int                ptr_m;
    logic [NREQ-1:0]   req_prev;
    logic [8*NREQ-1:0] data_prev;
    bit                active, first, saw_hi, busy_prev, expect_grant, after_ack;
    int                exp_win;
    logic [NREQ-1:0]   exp_grant;
    logic [7:0]        exp_byte;
    int                win_log[$];
    int                n_starts, n_acks;
    int                wait_cnt[NREQ];
    bit                rand_mode   = 1'b0;
    bit                drop_on_ack = 1'b0;
    bit                mon_en      = 1'b1;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] g);
        for (int k = 0; k < NREQ; k++) begin
            if (g[k]) return k;
        end
        return -1;
    endfunction

    task automatic latch_inputs();
        req_prev     = bus.req;
        data_prev    = bus.req_data;
        expect_grant = (bus.grant == '0) && (bus.req != '0);
    endtask

    task automatic reset_model();
        ptr_m     = 0;
        active    = 1'b0;
        after_ack = 1'b0;
        busy_prev = bus.tx_busy;
        for (int k = 0; k < NREQ; k++) wait_cnt[k] = 0;
        latch_inputs();
    endtask

    task automatic monitor();
        bit exp_ack;
        exp_ack = 1'b0;
        check("onehot", 32'($onehot0(bus.grant)), 1);
        if (bus.tx_start) n_starts++;
        if (bus.ack != '0) n_acks++;
        if (expect_grant) check("latency", 32'(bus.grant != '0), 1);
        if (after_ack) check("grant_clear", 32'(bus.grant), 0);
        if (!active && bus.grant != '0) begin
            exp_win   = rr_pick(req_prev, ptr_m);
            exp_grant = (exp_win < 0) ? '0 : NREQ'(1) << exp_win;
            exp_byte  = (exp_win < 0) ? 8'h00 : data_prev[8*exp_win +: 8];
            check("winner", 32'(bus.grant), 32'(exp_grant));
            for (int k = 0; k < NREQ; k++) begin
                if (k == exp_win) begin
                    check("starve", 32'(wait_cnt[k] <= NREQ - 1), 1);
                    wait_cnt[k] = 0;
                end else if (req_prev[k]) begin
                    wait_cnt[k]++;
                end else begin
                    wait_cnt[k] = 0;
                end
            end
            win_log.push_back(idx_of(bus.grant));
            active = 1'b1;
            first  = 1'b1;
            saw_hi = 1'b0;
        end
        if (active) begin
            check("tx_data", 32'(bus.tx_data), 32'(exp_byte));
            check("grant_hold", 32'(bus.grant), 32'(exp_grant));
            check("tx_start", 32'(bus.tx_start), 32'(first));
            exp_ack = !first && saw_hi && !busy_prev;
            check("ack", 32'(bus.ack), exp_ack ? 32'(exp_grant) : 0);
            check("err", 32'(bus.err), 0);
            if (!first && bus.tx_busy) saw_hi = 1'b1;
            if (exp_ack) begin
                active = 1'b0;
                ptr_m  = (exp_win + 1) % NREQ;
            end
            first = 1'b0;
        end else begin
            check("idle_ack", 32'(bus.ack), 0);
            check("idle_start", 32'(bus.tx_start), 0);
        end
        after_ack = exp_ack;
        busy_prev = bus.tx_busy;
    endtask

    task automatic drive_rand();
        logic [NREQ-1:0]   r;
        logic [8*NREQ-1:0] d;
        r        = bus.req;
        d        = bus.req_data;
        busy_len = int'($urandom_range(6, 1));
        for (int k = 0; k < NREQ; k++) begin
            if (bus.ack[k]) begin
                if ($urandom_range(1, 0) == 0) r[k] = 1'b0;
            end else if (!r[k] && $urandom_range(3, 0) == 0) begin
                r[k]         = 1'b1;
                d[8*k +: 8]  = 8'($urandom);
            end else if (bus.grant[k] && $urandom_range(7, 0) == 0) begin
                r[k] = 1'b0;
            end
            if ($urandom_range(7, 0) == 0) d[8*k +: 8] = 8'($urandom);
        end
        bus.req      = r;
        bus.req_data = d;
    endtask

    task automatic cycle();
        logic [NREQ-1:0] r;
        @(negedge clk);
        if (mon_en) monitor();
        if (rand_mode) begin
            drive_rand();
        end else if (drop_on_ack) begin
            r       = bus.req & ~bus.ack;
            bus.req = r;
        end
        latch_inputs();
    endtask

    task automatic set_req(input logic [NREQ-1:0] r, input logic [8*NREQ-1:0] d);
        bus.req      = r;
        bus.req_data = d;
        latch_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        reset_model();
    endtask

    task automatic run_until_grants(input int n, input int budget);
        int k = 0;
        while (win_log.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check("grant_wait", 32'(win_log.size() >= n), 1);
    endtask

    task automatic run_until_acks(input int n, input int budget);
        int k = 0;
        while (n_acks < n && k < budget) begin
            cycle();
            k++;
        end
        check("ack_wait", 32'(n_acks >= n), 1);
    endtask

    task automatic clear_log();
        win_log.delete();
        n_starts = 0;
        n_acks   = 0;
    endtask

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_start", 32'(bus.tx_start), 0);
        check("rst_data", 32'(bus.tx_data), 0);
        rst = 1'b1;
        reset_model();

        // Single requester, 10-cycle transmitter
        clear_log();
        busy_len    = 10;
        drop_on_ack = 1'b1;
        set_req(4'b0100, 32'h3CA5_7E11);
        run_until_acks(1, 60);
        repeat (5) cycle();
        check("single_starts", 32'(n_starts), 1);
        check("single_acks", 32'(n_acks), 1);
        check("single_win", 32'(win_log[0]), 2);
        check("single_data", 32'(bus.tx_data), 32'hA5);

        // Round-robin with all requests held
        do_reset();
        clear_log();
        busy_len    = 3;
        drop_on_ack = 1'b0;
        set_req(4'b1111, 32'h4433_2211);
        run_until_grants(5, 200);
        for (int k = 0; k < 5; k++) check("rr_order", 32'(win_log[k]), 32'(k % 4));
        set_req(4'b0000, 32'h0);
        repeat (15) cycle();

        // Pointer wrap: 3 first, then 0, then pointer sits at 1
        do_reset();
        clear_log();
        drop_on_ack = 1'b1;
        set_req(4'b0100, 32'h0);
        run_until_acks(1, 60);
        clear_log();
        set_req(4'b1001, 32'hD000_000C);
        run_until_acks(2, 80);
        check("wrap_first", 32'(win_log[0]), 3);
        check("wrap_second", 32'(win_log[1]), 0);
        repeat (3) cycle();
        clear_log();
        drop_on_ack = 1'b0;
        set_req(4'b1111, 32'h0);
        run_until_grants(1, 20);
        check("wrap_ptr", 32'(win_log[0]), 1);
        set_req(4'b0000, 32'h0);
        repeat (15) cycle();

        // Reset in the middle of WAIT_DONE, then tx_busy stuck high while idle
        do_reset();
        clear_log();
        busy_len = 10;
        set_req(4'b0100, 32'h0055_0000);
        run_until_grants(1, 20);
        repeat (4) cycle();
        check("midrst_busy", 32'(bus.tx_busy), 1);
        rst          = 1'b0;
        bus.req      = 4'b1010;
        bus.req_data = 32'h7700_6600;
        @(negedge clk);
        check("midrst_grant", 32'(bus.grant), 0);
        check("midrst_ack", 32'(bus.ack), 0);
        check("midrst_start", 32'(bus.tx_start), 0);
        check("midrst_data", 32'(bus.tx_data), 0);
        check("midrst_err", 32'(bus.err), 0);
        stuck = 2;
        rst   = 1'b1;
        reset_model();
        clear_log();
        drop_on_ack = 1'b1;
        busy_len    = 3;
        run_until_grants(1, 20);
        stuck = 0;
        check("midrst_next", 32'(win_log[0]), 1);
        run_until_acks(2, 80);

        // Drop request and change data after the grant
        set_req(4'b0000, 32'h0);
        repeat (15) cycle();
        clear_log();
        drop_on_ack = 1'b0;
        set_req(4'b0010, 32'h0000_1100);
        run_until_grants(1, 20);
        set_req(4'b0000, 32'h0000_2200);
        repeat (30) cycle();
        check("drop_acks", 32'(n_acks), 1);
        check("drop_data", 32'(bus.tx_data), 32'h11);

        // Randomized traffic
        do_reset();
        rand_mode = 1'b1;
        repeat (3000) cycle();
        rand_mode = 1'b0;
        set_req(4'b0000, 32'h0);
        repeat (30) cycle();

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: stuck low aborts from WAIT_BUSY, stuck high from WAIT_DONE
        mon_en = 1'b0;
        for (int s = 1; s <= 2; s++) begin
            int k;
            do_reset();
            stuck = s;
            set_req(4'b0001, 32'h0000_00EE);
            k = 0;
            while (bus.grant == '0 && k < 50) begin
                @(negedge clk);
                k++;
            end
            bus.req = '0;
            k = 0;
            while (bus.ack == '0 && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("to_latency", 32'(k), (s == 1) ? 21 : 22);
            check("to_err", 32'(bus.err), 1);
            check("to_ack", 32'(bus.ack), 1);
        end
        stuck  = 0;
        do_reset();
        mon_en = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
